// File: rtl/uart_echo_ctrl_if.sv
// Receive/transmit FIFO handshake bundle seen by the uart echo controller.
interface uart_echo_ctrl_if #(
   parameter int DBIT = 8
);
   logic            rx_empty;
   logic [DBIT-1:0] r_data;
   logic            rd_uart;
   logic            tx_full;
   logic [DBIT-1:0] w_data;
   logic            wr_uart;

   modport master (
      input  rx_empty, r_data, tx_full,
      output rd_uart, w_data, wr_uart
   );

   modport slave (
      output rx_empty, r_data, tx_full,
      input  rd_uart, w_data, wr_uart
   );
endinterface

// File: rtl/uart_echo_ctrl.sv
// Registered echo engine between uart rx and tx FIFOs: per-char echo or line-buffered replay.
// Optional feature macro: UART_ECHO_UPCASE_EN (lower-case a..z written out as upper case).
module uart_echo_ctrl #(
   parameter int          DBIT       = 8,
   parameter int          LINE_DEPTH = 16,
   parameter int          ADDR_W     = 4,
   parameter int unsigned EOL_CHAR   = 32'h0D
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   uart_echo_ctrl_if.master bus,
   output logic [DBIT-1:0]  last_rx,
   output logic [DBIT-1:0]  last_tx,
   output logic [ADDR_W:0]  line_len,
   output logic             ovf,
   output logic             busy
);

   localparam int              IW      = (ADDR_W > 0) ? ADDR_W : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(LINE_DEPTH);
   localparam logic [DBIT-1:0] EOL     = DBIT'(EOL_CHAR);

   if (LINE_DEPTH != (1 << ADDR_W)) begin : g_bad_depth
      $error("uart_echo_ctrl: LINE_DEPTH must equal 2**ADDR_W");
   end

`ifdef UART_ECHO_UPCASE_EN
   if (DBIT != 8) begin : g_bad_dbit
      $error("uart_echo_ctrl: UART_ECHO_UPCASE_EN requires DBIT == 8");
   end
`endif

   typedef enum logic [1:0] {IDLE, GAP, FLUSH, FLUSH_GAP} state_t;

   state_t          state, state_nxt;
   logic            mode_reg, mode_nxt;
   logic [ADDR_W:0] len_nxt;
   logic [ADDR_W:0] idx, idx_nxt;
   logic            rd_uart, rd_nxt;
   logic            wr_uart, wr_nxt;
   logic [DBIT-1:0] w_data, wdata_nxt;
   logic [DBIT-1:0] lrx_nxt, ltx_nxt;
   logic            ovf_nxt;
   logic            buf_we;
   logic [IW-1:0]   buf_wa;
   logic [DBIT-1:0] buf_wd;
   logic [DBIT-1:0] line_buf [LINE_DEPTH];

   // Mapping applied to every byte on its way to the transmit FIFO.
   function automatic logic [DBIT-1:0] echo_map(input logic [DBIT-1:0] b);
      logic [DBIT-1:0] r;
      r = b;
`ifdef UART_ECHO_UPCASE_EN
      if (b >= DBIT'(8'h61) && b <= DBIT'(8'h7A)) r[5] = 1'b0;
`endif
      return r;
   endfunction

   assign bus.rd_uart = rd_uart;
   assign bus.wr_uart = wr_uart;
   assign bus.w_data  = w_data;

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_reg;
      len_nxt   = line_len;
      idx_nxt   = idx;
      rd_nxt    = 1'b0;
      wr_nxt    = 1'b0;
      wdata_nxt = w_data;
      lrx_nxt   = last_rx;
      ltx_nxt   = last_tx;
      ovf_nxt   = ovf;
      buf_we    = 1'b0;
      buf_wa    = line_len[IW-1:0];
      buf_wd    = bus.r_data;
      case (state)
         IDLE: begin
            // Mode only switches between lines so a half-built line is never reinterpreted.
            if (line_len == '0) mode_nxt = mode;
            if (!mode_reg) begin
               if (!bus.rx_empty && !bus.tx_full) begin
                  rd_nxt    = 1'b1;
                  wr_nxt    = 1'b1;
                  wdata_nxt = echo_map(bus.r_data);
                  ltx_nxt   = echo_map(bus.r_data);
                  lrx_nxt   = bus.r_data;
                  state_nxt = GAP;
               end
            end else if (!bus.rx_empty) begin
               rd_nxt  = 1'b1;
               lrx_nxt = bus.r_data;
               if (line_len < DEPTH_L) begin
                  buf_we  = 1'b1;
                  len_nxt = line_len + 1'b1;
               end else begin
                  ovf_nxt = 1'b1;
               end
               if (bus.r_data == EOL) begin
                  idx_nxt   = '0;
                  state_nxt = FLUSH;
               end else begin
                  state_nxt = GAP;
               end
            end
         end
         GAP: state_nxt = IDLE;
         FLUSH: begin
            if (idx == line_len) begin
               len_nxt   = '0;
               state_nxt = IDLE;
            end else if (!bus.tx_full) begin
               wr_nxt    = 1'b1;
               wdata_nxt = echo_map(line_buf[idx[IW-1:0]]);
               ltx_nxt   = echo_map(line_buf[idx[IW-1:0]]);
               idx_nxt   = idx + 1'b1;
               state_nxt = FLUSH_GAP;
            end
         end
         FLUSH_GAP: state_nxt = FLUSH;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         mode_reg <= 1'b0;
         line_len <= '0;
         idx      <= '0;
         rd_uart  <= 1'b0;
         wr_uart  <= 1'b0;
         w_data   <= '0;
         last_rx  <= '0;
         last_tx  <= '0;
         ovf      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         mode_reg <= mode_nxt;
         line_len <= len_nxt;
         idx      <= idx_nxt;
         rd_uart  <= rd_nxt;
         wr_uart  <= wr_nxt;
         w_data   <= wdata_nxt;
         last_rx  <= lrx_nxt;
         last_tx  <= ltx_nxt;
         ovf      <= ovf_nxt;
         busy     <= (state_nxt != IDLE);
      end
   end

   // Line storage carries no reset; line_len alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (buf_we && !reset) line_buf[buf_wa] <= buf_wd;
   end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed bench for uart_echo_ctrl: char-mode vector table plus line-mode, stall, overflow and reset sequences.
module tb_uart_echo_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       mode;
   logic [7:0] last_rx, last_tx;
   logic [2:0] line_len;
   logic       ovf, busy;

   uart_echo_ctrl_if #(.DBIT(8)) bus ();

   uart_echo_ctrl #(
      .DBIT(8), .LINE_DEPTH(4), .ADDR_W(2), .EOL_CHAR(32'h0D)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .bus(bus.master),
      .last_rx(last_rx), .last_tx(last_tx), .line_len(line_len),
      .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic [7:0] w_plain;
      logic [7:0] w_up;
   } vec_t;

   vec_t       vecs [9];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         rd_cnt, wr_cnt, both_cnt, first_wr_rd, cyc, stall_left;
   bit         stall_arm, hold_full;
   logic [7:0] rxq [$];
   logic [7:0] txlog [$];
   int         wr_cyc [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic refresh_rx();
      bus.rx_empty = (rxq.size() == 0);
      bus.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      rxq.push_back(b);
      refresh_rx();
   endtask

   // FIFO model acts on the falling edge, away from the DUT's sampling edge.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (bus.rd_uart) begin
         rd_cnt++;
         if (rxq.size() > 0) void'(rxq.pop_front());
      end
      if (bus.wr_uart) begin
         if (wr_cnt == 0) first_wr_rd = rd_cnt;
         if (bus.rd_uart) both_cnt++;
         wr_cnt++;
         txlog.push_back(bus.w_data);
         wr_cyc.push_back(cyc);
         if (stall_arm) begin
            stall_arm  = 1'b0;
            stall_left = 10;
         end
      end
      bus.tx_full = hold_full || (stall_left > 0);
      if (stall_left > 0) stall_left--;
      refresh_rx();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clear_log();
      rd_cnt = 0; wr_cnt = 0; both_cnt = 0; first_wr_rd = -1;
      txlog.delete();
      wr_cyc.delete();
   endtask

   function automatic logic [31:0] tx_at(input int i);
      return (i < txlog.size()) ? 32'(txlog[i]) : 32'hFFFF_FFFF;
   endfunction

   initial begin
      logic [7:0] exp_w;
      vecs[0] = '{8'h41, 8'h41, 8'h41};
      vecs[1] = '{8'h55, 8'h55, 8'h55};
      vecs[2] = '{8'h00, 8'h00, 8'h00};
      vecs[3] = '{8'hFF, 8'hFF, 8'hFF};
      vecs[4] = '{8'h0D, 8'h0D, 8'h0D};
      vecs[5] = '{8'h61, 8'h61, 8'h41};
      vecs[6] = '{8'h7A, 8'h7A, 8'h5A};
      vecs[7] = '{8'h7B, 8'h7B, 8'h7B};
      vecs[8] = '{8'h60, 8'h60, 8'h60};

      reset = 1'b1; mode = 1'b0; hold_full = 1'b0; stall_arm = 1'b0; stall_left = 0; cyc = 0;
      bus.tx_full = 1'b0;
      refresh_rx();
      clear_log();
      run(3);
      check("reset rd_uart", 32'(bus.rd_uart), 0);
      check("reset wr_uart", 32'(bus.wr_uart), 0);
      check("reset w_data", 32'(bus.w_data), 0);
      check("reset last_rx", 32'(last_rx), 0);
      check("reset last_tx", 32'(last_tx), 0);
      check("reset line_len", 32'(line_len), 0);
      check("reset ovf", 32'(ovf), 0);
      check("reset busy", 32'(busy), 0);
      reset = 1'b0;
      run(2);

      // Char-mode echo table.
      for (int i = 0; i < 9; i++) begin
`ifdef UART_ECHO_UPCASE_EN
         exp_w = vecs[i].w_up;
`else
         exp_w = vecs[i].w_plain;
`endif
         clear_log();
         push(vecs[i].din);
         run(6);
         check($sformatf("char[%0d] rd count", i), rd_cnt, 1);
         check($sformatf("char[%0d] wr count", i), wr_cnt, 1);
         check($sformatf("char[%0d] same-cycle", i), both_cnt, 1);
         check($sformatf("char[%0d] w_data", i), tx_at(0), 32'(exp_w));
         check($sformatf("char[%0d] last_rx", i), 32'(last_rx), 32'(vecs[i].din));
         check($sformatf("char[%0d] last_tx", i), 32'(last_tx), 32'(exp_w));
         check($sformatf("char[%0d] busy", i), 32'(busy), 0);
      end

      // Char mode with tx_full held: the byte must stay in the rx FIFO.
      clear_log();
      hold_full = 1'b1;
      step();
      push(8'h55);
      run(20);
      check("full rd count", rd_cnt, 0);
      check("full wr count", wr_cnt, 0);
      check("full rx kept", rxq.size(), 1);
      hold_full = 1'b0;
      run(6);
      check("release rd count", rd_cnt, 1);
      check("release wr count", wr_cnt, 1);
      check("release w_data", tx_at(0), 32'h55);

      // Line mode "AB\r".
      mode = 1'b1;
      run(3);
      clear_log();
      push(8'h41); push(8'h42);
      run(8);
      check("line partial len", 32'(line_len), 2);
      check("line partial wr", wr_cnt, 0);
      check("line partial rd", rd_cnt, 2);
      push(8'h0D);
      run(30);
      check("line rd count", rd_cnt, 3);
      check("line wr count", wr_cnt, 3);
      check("line pops before write", first_wr_rd, 3);
      check("line tx0", tx_at(0), 32'h41);
      check("line tx1", tx_at(1), 32'h42);
      check("line tx2", tx_at(2), 32'h0D);
      check("line len after", 32'(line_len), 0);
      check("line busy after", 32'(busy), 0);
      check("line ovf", 32'(ovf), 0);
      check("line last_rx", 32'(last_rx), 32'h0D);

      // Line mode with tx stalled after the first write.
      clear_log();
      stall_arm = 1'b1;
      push(8'h41); push(8'h42); push(8'h0D);
      run(60);
      check("stall wr count", wr_cnt, 3);
      check("stall tx0", tx_at(0), 32'h41);
      check("stall tx1", tx_at(1), 32'h42);
      check("stall tx2", tx_at(2), 32'h0D);
      check("stall held", 32'(wr_cyc.size() >= 2 && (wr_cyc[1] - wr_cyc[0]) >= 10), 1);

      // Overflow: 4-entry buffer with "ABCDEF\r".
      clear_log();
      push(8'h41); push(8'h42); push(8'h43); push(8'h44);
      push(8'h45); push(8'h46); push(8'h0D);
      run(60);
      check("ovf rd count", rd_cnt, 7);
      check("ovf wr count", wr_cnt, 4);
      check("ovf tx0", tx_at(0), 32'h41);
      check("ovf tx3", tx_at(3), 32'h44);
      check("ovf flag", 32'(ovf), 1);
      check("ovf len after", 32'(line_len), 0);
      push(8'h5A); push(8'h0D);
      run(30);
      check("ovf next wr count", wr_cnt, 6);
      check("ovf next tx4", tx_at(4), 32'h5A);
      check("ovf next tx5", tx_at(5), 32'h0D);
      check("ovf sticky", 32'(ovf), 1);

      // Reset during flush, right after the first write.
      clear_log();
      push(8'h41); push(8'h42); push(8'h43); push(8'h0D);
      for (int k = 0; k < 40; k++) begin
         if (wr_cnt >= 1) break;
         step();
      end
      check("rst first write", tx_at(0), 32'h41);
      reset = 1'b1;
      step();
      check("rst wr low", 32'(bus.wr_uart), 0);
      check("rst busy low", 32'(busy), 0);
      step();
      reset = 1'b0;
      run(20);
      check("rst wr count", wr_cnt, 1);
      check("rst line_len", 32'(line_len), 0);
      check("rst busy", 32'(busy), 0);
      check("rst ovf cleared", 32'(ovf), 0);
      check("rst last_tx", 32'(last_tx), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
